// File: rtl/signal_conflict_monitor.sv
// signal_conflict_monitor
// Watches the six lamp drives of a traffic_light controller for illegal
// combinations and forces the controller into flash when a conflict persists.
// A short glitch run is debounced (SUSPECT); a persistent one latches FAULT,
// and an operator clear followed by a run of legal cycles (RECOVER) releases
// the flash request again.
// Build option: define CONFLICT_MON_COUNT_EN to implement the saturating
// fault_count register; when undefined, fault_count is tied to zero.
module signal_conflict_monitor #(
    parameter int CONFLICT_CYCLES = 3,   // 1..15 consecutive violating edges
    parameter int CLEAR_CYCLES    = 8    // 1..255 consecutive legal edges
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       NSG,
    input  logic       NSY,
    input  logic       NSR,
    input  logic       EWG,
    input  logic       EWY,
    input  logic       EWR,
    input  logic       flash_in,
    input  logic       clear,
    output logic       flash_req,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count
);

    localparam logic [3:0] CONFLICT_LIM = 4'(CONFLICT_CYCLES);
    localparam logic [7:0] CLEAR_LIM    = 8'(CLEAR_CYCLES);

    typedef enum logic [1:0] {
        ST_OK,
        ST_SUSPECT,
        ST_FAULT,
        ST_RECOVER
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] run_cnt_reg, run_cnt_next;
    logic [2:0] acc_reg, acc_next;
    logic [7:0] legal_cnt_reg, legal_cnt_next;
    logic       flash_req_next;
    logic       fault_next;
    logic [2:0] fault_code_next;

    logic       ns_one_lit;
    logic       ew_one_lit;
    logic       head_viol;
    logic       cross_viol;
    logic       flashpat_viol;
    logic [2:0] classes;
    logic       violation;

    // Classify the current lamp pattern; an odd XOR count minus the all-three
    // case gives "exactly one lamp lit" per head.
    always_comb begin
        ns_one_lit    = (NSG ^ NSY ^ NSR) & ~(NSG & NSY & NSR);
        ew_one_lit    = (EWG ^ EWY ^ EWR) & ~(EWG & EWY & EWR);
        head_viol     = ~flash_in & ~(ns_one_lit & ew_one_lit);
        cross_viol    = (NSG | NSY) & (EWG | EWY);
        flashpat_viol = flash_in &
                        ({NSG, NSY, NSR, EWG, EWY, EWR} != 6'b001001) &
                        ({NSG, NSY, NSR, EWG, EWY, EWR} != 6'b000000);
        classes       = {flashpat_viol, cross_viol, head_viol};
        violation     = |classes;
    end

    // Next-state and next-output logic; every output is computed here and
    // registered below so no input reaches an output combinationally.
    always_comb begin
        state_next      = state_reg;
        run_cnt_next    = run_cnt_reg;
        acc_next        = acc_reg;
        legal_cnt_next  = legal_cnt_reg;
        flash_req_next  = flash_req;
        fault_next      = fault;
        fault_code_next = fault_code;

        case (state_reg)
            ST_OK: begin
                if (violation) begin
                    if (CONFLICT_LIM == 4'd1) begin
                        state_next      = ST_FAULT;
                        fault_next      = 1'b1;
                        flash_req_next  = 1'b1;
                        fault_code_next = classes;
                        run_cnt_next    = 4'd0;
                        acc_next        = 3'd0;
                    end else begin
                        state_next   = ST_SUSPECT;
                        run_cnt_next = 4'd1;
                        acc_next     = classes;
                    end
                end
            end
            ST_SUSPECT: begin
                if (violation) begin
                    if (run_cnt_reg + 4'd1 == CONFLICT_LIM) begin
                        state_next      = ST_FAULT;
                        fault_next      = 1'b1;
                        flash_req_next  = 1'b1;
                        fault_code_next = acc_reg | classes;
                        run_cnt_next    = 4'd0;
                        acc_next        = 3'd0;
                    end else begin
                        run_cnt_next = run_cnt_reg + 4'd1;
                        acc_next     = acc_reg | classes;
                    end
                end else begin
                    // Glitch ended before the debounce limit: forget it.
                    state_next   = ST_OK;
                    run_cnt_next = 4'd0;
                    acc_next     = 3'd0;
                end
            end
            ST_FAULT: begin
                // An acknowledge is only honoured while the lamps are legal.
                if (clear && !violation) begin
                    state_next     = ST_RECOVER;
                    fault_next     = 1'b0;
                    legal_cnt_next = 8'd0;
                end
            end
            ST_RECOVER: begin
                if (violation) begin
                    state_next      = ST_FAULT;
                    fault_next      = 1'b1;
                    fault_code_next = classes;
                    legal_cnt_next  = 8'd0;
                end else if (legal_cnt_reg + 8'd1 == CLEAR_LIM) begin
                    state_next      = ST_OK;
                    flash_req_next  = 1'b0;
                    fault_code_next = 3'd0;
                    legal_cnt_next  = 8'd0;
                end else begin
                    legal_cnt_next = legal_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_OK;
            end
        endcase
    end

    // State, counters and registered outputs; reset discards any latched fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_OK;
            run_cnt_reg   <= 4'd0;
            acc_reg       <= 3'd0;
            legal_cnt_reg <= 8'd0;
            flash_req     <= 1'b0;
            fault         <= 1'b0;
            fault_code    <= 3'd0;
        end else begin
            state_reg     <= state_next;
            run_cnt_reg   <= run_cnt_next;
            acc_reg       <= acc_next;
            legal_cnt_reg <= legal_cnt_next;
            flash_req     <= flash_req_next;
            fault         <= fault_next;
            fault_code    <= fault_code_next;
        end
    end

`ifdef CONFLICT_MON_COUNT_EN
    logic       fault_entry;
    logic [7:0] fault_count_reg;

    assign fault_entry = (state_next == ST_FAULT) && (state_reg != ST_FAULT);

    // Count every entry into FAULT, holding at 255 rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_count_reg <= 8'd0;
        end else if (fault_entry && (fault_count_reg != 8'hFF)) begin
            fault_count_reg <= fault_count_reg + 8'd1;
        end
    end

    assign fault_count = fault_count_reg;
`else
    assign fault_count = 8'd0;
`endif

endmodule
